// File: rtl/seg7_count_display.sv
// Two-digit multiplexed common-anode seven-segment driver for a 0-31 count.
// The count is snapshotted once per frame; ones then tens are scanned with a dead cycle between.
module seg7_count_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_LEAD  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] value,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dp
);

  localparam int            CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          sel_r;
  logic [4:0]    snap_r;
  logic          tick_s;
  logic [1:0]    tens_s;
  logic [4:0]    ones_s;
  logic [6:0]    tens_seg_s;
  logic [6:0]    seg_r;
  logic [1:0]    an_r;
  logic          dp_r;

  function automatic logic [6:0] enc(input logic [4:0] d);
    logic [6:0] r;
    case (d)
      5'd0:    r = 7'h40;
      5'd1:    r = 7'h79;
      5'd2:    r = 7'h24;
      5'd3:    r = 7'h30;
      5'd4:    r = 7'h19;
      5'd5:    r = 7'h12;
      5'd6:    r = 7'h02;
      5'd7:    r = 7'h78;
      5'd8:    r = 7'h00;
      5'd9:    r = 7'h10;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  assign tick_s = (cnt_r == CNT_LAST);

  // Binary to two-digit decimal split of the snapshot, with optional tens blanking
  always_comb begin
    tens_s     = 2'd0;
    ones_s     = snap_r;
    tens_seg_s = 7'h7F;
    if (snap_r >= 5'd30) begin
      tens_s = 2'd3;
      ones_s = snap_r - 5'd30;
    end else if (snap_r >= 5'd20) begin
      tens_s = 2'd2;
      ones_s = snap_r - 5'd20;
    end else if (snap_r >= 5'd10) begin
      tens_s = 2'd1;
      ones_s = snap_r - 5'd10;
    end else begin
      tens_s = 2'd0;
      ones_s = snap_r;
    end
    if ((BLANK_LEAD == 1) && (tens_s == 2'd0)) begin
      tens_seg_s = 7'h7F;
    end else begin
      tens_seg_s = enc({3'b000, tens_s});
    end
  end

  // Refresh counter, digit select, and snapshot taken at the tens-to-ones frame boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r  <= '0;
      sel_r  <= 1'b0;
      snap_r <= 5'd0;
    end else if (tick_s) begin
      cnt_r <= '0;
      sel_r <= ~sel_r;
      if (sel_r) begin
        snap_r <= value;
      end
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Registered digit drive; the tick cycle is forced dark to avoid ghosting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= 2'b11;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else if (tick_s) begin
      an_r  <= 2'b11;
      seg_r <= 7'h7F;
      dp_r  <= 1'b1;
    end else if (!sel_r) begin
      an_r  <= 2'b10;
      seg_r <= enc(ones_s);
      dp_r  <= 1'b1;
    end else begin
      an_r  <= 2'b01;
      seg_r <= tens_seg_s;
      dp_r  <= 1'b1;
    end
  end

  assign seg = seg_r;
  assign an  = an_r;
  assign dp  = dp_r;

endmodule

// File: tb/tb_seg7_count_display.sv
// Randomized scenario bench for seg7_count_display against a slot/frame position model.
// Three instances: REFRESH_DIV=4 blanked, REFRESH_DIV=4 unblanked, REFRESH_DIV=2 blanked.
module tb_seg7_count_display;

  localparam int RD  = 4;
  localparam int RD2 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] value = 5'd17;
  logic [6:0] seg_a, seg_b, seg_c;
  logic [1:0] an_a, an_b, an_c;
  logic       dp_a, dp_b, dp_c;
  logic [29:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int k4 = 0, fv4 = 0, k2 = 0, fv2 = 0;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg7_count_display #(.REFRESH_DIV(RD), .BLANK_LEAD(1)) dut_a (
    .clk(clk), .rst(rst), .value(value), .seg(seg_a), .an(an_a), .dp(dp_a));
  seg7_count_display #(.REFRESH_DIV(RD), .BLANK_LEAD(0)) dut_b (
    .clk(clk), .rst(rst), .value(value), .seg(seg_b), .an(an_b), .dp(dp_b));
  seg7_count_display #(.REFRESH_DIV(RD2), .BLANK_LEAD(1)) dut_c (
    .clk(clk), .rst(rst), .value(value), .seg(seg_c), .an(an_c), .dp(dp_c));

  assign obs = {an_a, seg_a, dp_a, an_b, seg_b, dp_b, an_c, seg_c, dp_c};

  always #5 clk = ~clk;

  // Edge count since reset release; the displayed number is the value seen at each frame-end edge
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      k4 <= 0; fv4 <= 0; k2 <= 0; fv2 <= 0;
    end else begin
      k4 <= k4 + 1;
      k2 <= k2 + 1;
      if ((k4 + 1) % (2 * RD) == 0)  fv4 <= int'(value);
      if ((k2 + 1) % (2 * RD2) == 0) fv2 <= int'(value);
    end
  end

  function automatic logic [9:0] exp_out(int k, int fv, int rd, bit blank);
    int p;
    if (k == 0) return {2'b11, 7'h7F, 1'b1};
    p = (k - 1) % (2 * rd);
    if (p % rd == rd - 1) return {2'b11, 7'h7F, 1'b1};
    if (p < rd) return {2'b10, seg_tbl[fv % 10], 1'b1};
    if (blank && (fv / 10 == 0)) return {2'b01, 7'h7F, 1'b1};
    return {2'b01, seg_tbl[fv / 10], 1'b1};
  endfunction

  function automatic logic [29:0] exp_all();
    return {exp_out(k4, fv4, RD, 1'b1), exp_out(k4, fv4, RD, 1'b0), exp_out(k2, fv2, RD2, 1'b1)};
  endfunction

  task automatic test_reset();
    logic [29:0] rv;
    rv = {3{2'b11, 7'h7F, 1'b1}};
    rst = 1'b1;
    #1 rst = 1'b0;
    value = 5'd17;
    #1;
    n_checks++;
    if (obs !== rv) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs, rv); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== rv) begin n_fail++; $display("FAIL reset_hold_clk: got %h expected %h", obs, rv); end
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({an_a, seg_a} !== {2'b10, 7'h40}) begin
      n_fail++; $display("FAIL reset_first_edge: got an=%b seg=%h expected an=10 seg=40", an_a, seg_a);
    end
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_all()) begin n_fail++; $display("FAIL reset_scan k=%0d: got %h expected %h", k4, obs, exp_all()); end
      if (k4 <= 2 * RD && an_a == 2'b01) begin
        n_checks++;
        if (seg_a !== 7'h7F) begin n_fail++; $display("FAIL reset_frame1_tens: got %h expected 7f", seg_a); end
      end
      if (k4 > 2 * RD && an_a == 2'b01) begin
        n_checks++;
        if (seg_a !== 7'h79) begin n_fail++; $display("FAIL reset_frame2_tens: got %h expected 79", seg_a); end
      end
      if (k4 > 2 * RD && an_a == 2'b10) begin
        n_checks++;
        if (seg_a !== 7'h78) begin n_fail++; $display("FAIL reset_frame2_ones: got %h expected 78", seg_a); end
      end
    end
  endtask

  task automatic test_blanking();
    value = 5'd5;
    for (int i = 0; i < 6 * RD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_all()) begin n_fail++; $display("FAIL blank k=%0d: got %h expected %h", k4, obs, exp_all()); end
      if (fv4 == 5 && an_a == 2'b01) begin
        n_checks++;
        if ({seg_a, an_b, seg_b} !== {7'h7F, 2'b01, 7'h40}) begin
          n_fail++; $display("FAIL blank_tens: got a=%h b=%b/%h expected 7f 01/40", seg_a, an_b, seg_b);
        end
      end
    end
  endtask

  task automatic test_range();
    int vals[8] = '{27, 31, 10, 0, 9, 19, 30, 20};
    foreach (vals[j]) begin
      value = 5'(vals[j]);
      for (int i = 0; i < 6 * RD; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== exp_all()) begin
          n_fail++; $display("FAIL range v=%0d k=%0d: got %h expected %h", vals[j], k4, obs, exp_all());
        end
      end
    end
  endtask

  task automatic test_snapshot();
    bit found = 1'b0;
    value = 5'd19;
    for (int i = 0; i < 8 * RD && !found; i++) begin
      @(negedge clk);
      if (fv4 == 19 && k4 % (2 * RD) == 2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL snapshot_align: got no aligned frame, expected one"); end
    value = 5'd20;
    for (int i = 0; i < 2 * RD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_all()) begin n_fail++; $display("FAIL snapshot k=%0d: got %h expected %h", k4, obs, exp_all()); end
      if (i < 2 * RD - 2 && an_a != 2'b11) begin
        n_checks++;
        if (seg_a !== ((an_a == 2'b01) ? 7'h79 : 7'h10)) begin
          n_fail++; $display("FAIL snapshot_tear: got an=%b seg=%h expected old digits 1/9", an_a, seg_a);
        end
      end
    end
    n_checks++;
    if ({an_a, seg_a} !== {2'b10, 7'h40}) begin
      n_fail++; $display("FAIL snapshot_next: got an=%b seg=%h expected 10/40", an_a, seg_a);
    end
  endtask

  task automatic test_dead_scan();
    logic [1:0] prev, before_dead;
    @(negedge clk);
    prev = an_a;
    before_dead = 2'b00;
    for (int i = 0; i < 200 * RD; i++) begin
      if ($urandom_range(0, 9) == 0) value = 5'($urandom_range(0, 31));
      @(negedge clk);
      n_checks++;
      if (obs !== exp_all()) begin n_fail++; $display("FAIL scan k=%0d: got %h expected %h", k4, obs, exp_all()); end
      n_checks++;
      if (an_a == 2'b00 || an_b == 2'b00 || an_c == 2'b00) begin
        n_fail++; $display("FAIL overlap: got %b %b %b expected no 00", an_a, an_b, an_c);
      end
      n_checks++;
      if (an_a == 2'b11) begin
        if (prev == 2'b11) begin n_fail++; $display("FAIL dead_len: got two dead cycles, expected one"); end
        before_dead = prev;
      end else if (prev == 2'b11) begin
        if (an_a === before_dead) begin n_fail++; $display("FAIL scan_order: got %b after dead, expected other digit", an_a); end
      end else if (an_a !== prev) begin
        n_fail++; $display("FAIL scan_switch: got %b after %b, expected a dead cycle between", an_a, prev);
      end
      prev = an_a;
    end
  endtask

  task automatic test_async_reset();
    logic [29:0] rv;
    bit found = 1'b0;
    rv = {3{2'b11, 7'h7F, 1'b1}};
    value = 5'd23;
    for (int i = 0; i < 4 * RD && !found; i++) begin
      @(negedge clk);
      if (k4 % (2 * RD) == RD + 2) found = 1'b1;
    end
    n_checks++;
    if (!found) begin n_fail++; $display("FAIL areset_align: got no tens slot, expected one"); end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== rv) begin n_fail++; $display("FAIL areset_immediate: got %h expected %h", obs, rv); end
    #1 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({an_a, seg_a, an_c, seg_c} !== {2'b10, 7'h40, 2'b10, 7'h40}) begin
      n_fail++; $display("FAIL areset_restart: got %b/%h %b/%h expected 10/40", an_a, seg_a, an_c, seg_c);
    end
    for (int i = 0; i < 4 * RD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_all()) begin n_fail++; $display("FAIL areset_scan k=%0d: got %h expected %h", k4, obs, exp_all()); end
    end
  endtask

  initial begin
    test_reset();
    test_blanking();
    test_range();
    test_snapshot();
    test_dead_scan();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
